// File: rtl/configure.sv
// configure: responder defaults and state encoding
package configure;
   localparam int ram_depth_default   = 10;
   localparam int ram_latency_default = 1;
   typedef enum logic [1:0] {st_idle, st_wait, st_resp} state_type;
endpackage

// File: rtl/wires.sv
// wires: request/response bundles shared by memory ports
package wires;
   typedef struct packed {
      logic        valid;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_in_type;
   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
   } mem_out_type;
endpackage

// File: rtl/ram_array.sv
// ram_array: single-port synchronous RAM with byte-write strobes and registered read
module ram_array #(
   parameter int depth = 10
) (
   input  logic             clock,
   input  logic             en,
   input  logic [3:0]       we,
   input  logic [depth-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);
   logic [31:0] mem [0:2**depth-1];
   // byte-lane writes and one-cycle read, both only when enabled
   always_ff @(posedge clock) begin
      if (en) begin
         for (int k = 0; k < 4; k++)
            if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
         rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/memory_responder.sv
// memory_responder: instruction/data memory responder serving one request at a time with fixed latency
module memory_responder
   import wires::*, configure::*;
#(
   parameter int ram_depth   = ram_depth_default,
   parameter int ram_latency = ram_latency_default
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        imemory_valid,
   input  logic        imemory_instr,
   input  logic [31:0] imemory_addr,
   input  logic [31:0] imemory_wdata,
   input  logic [3:0]  imemory_wstrb,
   output logic [31:0] imemory_rdata,
   output logic        imemory_ready,
   input  logic        dmemory_valid,
   input  logic        dmemory_instr,
   input  logic [31:0] dmemory_addr,
   input  logic [31:0] dmemory_wdata,
   input  logic [3:0]  dmemory_wstrb,
   output logic [31:0] dmemory_rdata,
   output logic        dmemory_ready
);
   mem_in_type  imem_in, dmem_in, req, req_next;
   mem_out_type imem_out, dmem_out;
   state_type   state, state_next;
   logic [3:0]  count, count_next;
   logic        grant, grant_next;
   logic        oor, rd_ok, i_hit, d_hit, ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata;
   logic        unused_req;
   assign imem_in = '{valid: imemory_valid, instr: imemory_instr, addr: imemory_addr, wdata: imemory_wdata, wstrb: imemory_wstrb};
   assign dmem_in = '{valid: dmemory_valid, instr: dmemory_instr, addr: dmemory_addr, wdata: dmemory_wdata, wstrb: dmemory_wstrb};
   assign unused_req = ^{req.valid, req.instr, req.addr[1:0]};
   assign oor   = |(req.addr >> (ram_depth + 2));
   assign rd_ok = req.wstrb == 4'h0 && !oor;
   // ready is masked by reset so an abandoned request never pulses
   assign i_hit = state == st_resp && !grant && reset;
   assign d_hit = state == st_resp && grant && reset;
   assign imem_out = '{rdata: i_hit && rd_ok ? ram_rdata : 32'h0, ready: i_hit};
   assign dmem_out = '{rdata: d_hit && rd_ok ? ram_rdata : 32'h0, ready: d_hit};
   assign imemory_rdata = imem_out.rdata;
   assign imemory_ready = imem_out.ready;
   assign dmemory_rdata = dmem_out.rdata;
   assign dmemory_ready = dmem_out.ready;
   // the read is launched in the last WAIT cycle so the registered RAM output lines up with RESP
   assign ram_we = state == st_resp && reset && !oor ? req.wstrb : 4'h0;
   assign ram_en = (state == st_wait && count == 4'h0) || |ram_we;
   ram_array #(.depth(ram_depth)) u_ram (
      .clock(clock),
      .en   (ram_en),
      .we   (ram_we),
      .addr (req.addr[ram_depth+1:2]),
      .wdata(req.wdata),
      .rdata(ram_rdata)
   );
   // next-state: arbitrate in IDLE (alternate under contention), count down in WAIT, respond once
   always_comb begin
      state_next = state;
      count_next = count;
      grant_next = grant;
      req_next   = req;
      case (state)
         st_idle: if (imem_in.valid || dmem_in.valid) begin
            grant_next = dmem_in.valid && !(imem_in.valid && grant);
            req_next   = grant_next ? dmem_in : imem_in;
            count_next = 4'(ram_latency);
            state_next = st_wait;
         end
         st_wait: if (count == 4'h0) state_next = st_resp;
                  else count_next = count - 4'h1;
         default: state_next = st_idle;
      endcase
   end
   // state register; grant doubles as the last-grant record for arbitration
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= st_idle;
         count <= 4'h0;
         grant <= 1'b0;
         req   <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         grant <= grant_next;
         req   <= req_next;
      end
   end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench over three latency variants of the responder
module tb_memory_responder;
   typedef struct {
      int          inst;
      bit          port;
      logic [31:0] rdata;
      int          due;
   } entry_t;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic        iv [3], ii [3], irdy [3], dv [3], di [3], drdy [3];
   logic [31:0] ia [3], iw [3], ird [3], da [3], dw [3], drd [3];
   logic [3:0]  ist [3], dst [3];
   entry_t      sbq [$];
   entry_t      e;
   logic [31:0] model_mem [int];
   logic [31:0] c_addr [2][4];
   logic [31:0] c_wd [2][4];
   logic [3:0]  c_ws [2][4];

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      memory_responder #(.ram_latency(g == 0 ? 1 : (g == 1 ? 0 : 15))) dut (
         .clock(clock), .reset(reset),
         .imemory_valid(iv[g]), .imemory_instr(ii[g]), .imemory_addr(ia[g]),
         .imemory_wdata(iw[g]), .imemory_wstrb(ist[g]), .imemory_rdata(ird[g]), .imemory_ready(irdy[g]),
         .dmemory_valid(dv[g]), .dmemory_instr(di[g]), .dmemory_addr(da[g]),
         .dmemory_wdata(dw[g]), .dmemory_wstrb(dst[g]), .dmemory_rdata(drd[g]), .dmemory_ready(drdy[g])
      );
   end

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      return i == 0 ? 1 : (i == 1 ? 0 : 15);
   endfunction

   function automatic logic [31:0] model_access(input int i, input logic [31:0] a, w, input logic [3:0] s);
      int key;
      logic [31:0] word;
      if (a >= 32'h1000) return 32'h0;
      key = i * 4096 + int'(a / 4);
      word = model_mem.exists(key) ? model_mem[key] : 32'h0;
      if (s == 4'h0) return word;
      for (int k = 0; k < 4; k++)
         if (s[k]) word[8*k +: 8] = w[8*k +: 8];
      model_mem[key] = word;
      return 32'h0;
   endfunction

   task automatic push(input int i, input bit p, input logic [31:0] a, w, input logic [3:0] s, input int due);
      sbq.push_back('{i, p, model_access(i, a, w, s), due});
   endtask

   task automatic set_port(input int i, input bit p, input logic v, input logic [31:0] a, w, input logic [3:0] s);
      if (p) begin
         dv[i] = v; da[i] = a; dw[i] = w; dst[i] = s;
      end else begin
         iv[i] = v; ia[i] = a; iw[i] = w; ist[i] = s;
      end
   endtask

   task automatic wait_ready(input int i, input bit p);
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (p ? drdy[i] : irdy[i]) return;
      end
      checks++;
      failures++;
      $display("FAIL timeout inst=%0d port=%0d got no ready within 40 cycles, required a ready", i, p);
   endtask

   task automatic req(input int i, input bit p, input logic [31:0] a, w, input logic [3:0] s);
      push(i, p, a, w, s, cyc + 2 + lat_of(i));
      set_port(i, p, 1'b1, a, w, s);
      wait_ready(i, p);
      @(negedge clock);
      set_port(i, p, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic port_seq(input bit p);
      for (int k = 0; k < 4; k++) begin
         set_port(0, p, 1'b1, c_addr[p][k], c_wd[p][k], c_ws[p][k]);
         wait_ready(0, p);
         @(negedge clock);
         set_port(0, p, 1'b0, 32'h0, 32'h0, 4'h0);
      end
   endtask

   // compare every response against the oldest outstanding expectation; idle ports must read 0
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ((!irdy[i] && ird[i] != 32'h0) || (!drdy[i] && drd[i] != 32'h0)) begin
            failures++;
            $display("FAIL idle_rdata inst=%0d irdata=%h drdata=%h required 0 on non-ready ports", i, ird[i], drd[i]);
         end
         if (irdy[i] || drdy[i]) begin
            checks++;
            if (irdy[i] && drdy[i]) begin
               failures++;
               $display("FAIL both_ready inst=%0d both ports ready, required one", i);
            end else if (sbq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_ready inst=%0d port=%0d with nothing outstanding", i, drdy[i]);
            end else begin
               e = sbq.pop_front();
               if (e.inst != i || e.port != drdy[i] || (drdy[i] ? drd[i] : ird[i]) != e.rdata) begin
                  failures++;
                  $display("FAIL resp got inst=%0d port=%0d rdata=%h required inst=%0d port=%0d rdata=%h",
                           i, drdy[i], drdy[i] ? drd[i] : ird[i], e.inst, e.port, e.rdata);
               end
               if (e.due >= 0) begin
                  checks++;
                  if (cyc != e.due) begin
                     failures++;
                     $display("FAIL latency inst=%0d ready at cycle %0d required %0d", i, cyc, e.due);
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [3:0] s;
      bit p;
      for (int i = 0; i < 3; i++) begin
         set_port(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         set_port(i, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
         ii[i] = 1'b1;
         di[i] = 1'b0;
      end
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      req(0, 1, 32'h10, 32'h0, 4'h0);
      req(0, 1, 32'h20, 32'h11223344, 4'hF);
      req(0, 1, 32'h20, 32'hAABBCCDD, 4'h5);
      req(0, 1, 32'h20, 32'h0, 4'h0);
      for (int w = 0; w < 16; w++)
         if (w != 4 && w != 8) req(0, w[0], w * 4, $urandom, 4'hF);
      req(0, 0, 32'h30, 32'h0, 4'hF);
      req(0, 1, 32'h1000, 32'h12345678, 4'hF);
      req(0, 1, 32'h0, 32'h0, 4'h0);
      req(0, 0, 32'h80001000, 32'h0, 4'h0);
      push(0, 0, 32'h8, 32'h0, 4'h0, cyc + 3);
      set_port(0, 0, 1'b1, 32'h8, 32'h0, 4'h0);
      @(negedge clock);
      set_port(0, 0, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_ready(0, 0);
      @(negedge clock);
      set_port(0, 1, 1'b1, 32'h30, 32'h55667788, 4'hF);
      @(negedge clock);
      reset = 1'b0;
      set_port(0, 1, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         c_addr[0][k] = 32'(k * 4 + 1);
         c_wd[0][k] = 32'h0;
         c_ws[0][k] = 4'h0;
         c_addr[1][k] = 32'(16 + k * 4);
         c_wd[1][k] = $urandom;
         c_ws[1][k] = k[0] ? 4'h0 : 4'hF;
      end
      for (int k = 0; k < 4; k++) begin
         push(0, 1, c_addr[1][k], c_wd[1][k], c_ws[1][k], -1);
         push(0, 0, c_addr[0][k], c_wd[0][k], c_ws[0][k], -1);
      end
      fork
         port_seq(1'b0);
         port_seq(1'b1);
      join
      req(0, 1, 32'h30, 32'h0, 4'h0);
      for (int n = 0; n < 40; n++) begin
         p = 1'($urandom_range(0, 1));
         a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
         s = $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0;
         req(0, p, a, $urandom, s);
      end
      for (int i = 1; i < 3; i++) begin
         req(i, 1, 32'h40, $urandom, 4'hF);
         req(i, 0, 32'h40, 32'h0, 4'h0);
         req(i, 1, 32'h40, $urandom, 4'h6);
         req(i, 1, 32'h42, 32'h0, 4'h0);
         req(i, 0, 32'h2000, 32'h0, 4'h0);
      end
      repeat (5) @(negedge clock);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain %0d responses outstanding, required 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ram_depth, default 10, log2 of word count (1024 x 32-bit words).
REQ-002 Parameter ram_latency, default 1, wait cycles between acceptance and response; legal range 0..15.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 imemory_valid  in  1  instruction-port request.
REQ-006 imemory_instr  in  1  fetch marker; ignored functionally.
REQ-007 imemory_addr  in  32  byte address.
REQ-008 imemory_wdata  in  32  write data.
REQ-009 imemory_wstrb  in  4  byte strobes; 0 means read.
REQ-010 imemory_rdata  out  32  read data.
REQ-011 imemory_ready  out  1  one-cycle response pulse.
REQ-012 dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb, dmemory_rdata, dmemory_ready: the same as REQ-005..REQ-011 for the data port.

Function
REQ-013 Protocol: the initiator holds valid and its payload stable until ready; ready is a single-cycle pulse; rdata is valid only in the ready cycle.
REQ-014 FSM states: IDLE, WAIT, RESP; exactly one request is in service at a time.
REQ-015 IDLE: if any valid is high, latch the granted port's addr/wdata/wstrb/port id, load the counter with ram_latency, and go to WAIT; otherwise stay in IDLE.
REQ-016 Arbitration in IDLE: a single requester wins; if both request, the data port wins unless the previous grant was data, in which case the instruction port wins (alternating under contention).
REQ-017 WAIT: if the counter is 0, go to RESP; otherwise decrement the counter.
REQ-018 RESP: assert ready only on the granted port and perform the access; next state is IDLE.
REQ-019 Latency: a request sampled in IDLE at cycle t gets ready at cycle t+2+ram_latency; minimum 2 cycles at ram_latency=0.
REQ-020 Read (wstrb=0): rdata = mem[addr[ram_depth+1:2]]; addr[1:0] is ignored.
REQ-021 Write (wstrb!=0): byte lane k of the word is updated with wdata lane k only where wstrb[k]=1; rdata=0 in the ready cycle.
REQ-022 Out of range (addr[31:ram_depth+2] != 0): ready is still given, rdata=0, and memory is unchanged.
REQ-023 The non-granted port's ready and rdata stay 0 throughout; its pending valid is served in a later IDLE.
REQ-024 Valid dropping during WAIT (protocol violation): the latched request still completes; no hang.
REQ-025 Back-to-back: a request still asserted in the cycle after RESP is treated as a new request; initiators drop valid or present a new request after ready.
REQ-026 A read issued after a write to the same address returns the written data; there is no stale-read window.

Reset
REQ-027 reset=0 at a rising edge: state=IDLE, counter=0, last-grant=instruction, all ready=0, all rdata=0.
REQ-028 Reset during WAIT or RESP: the in-flight request is abandoned with no ready pulse and no memory write.
REQ-029 Memory contents are not initialised by reset; they are preloadable by simulation only.

Structure
REQ-030 The responder state enum and the defaults for ram_depth and ram_latency belong in package configure.
REQ-031 The port signal groups reuse mem_in_type and mem_out_type from package wires.
REQ-032 One sub-module, ram_array: single-port synchronous RAM with byte-write strobes and a 1-cycle read; the FSM issues the read one cycle before RESP so that rdata is aligned.

Verification
REQ-033 ram_latency=1: dmem write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then read 0x10 -> ready 3 cycles after acceptance, rdata 0xDEADBEEF.
REQ-034 Byte strobes: word 0x20 = 0x11223344, then write wdata 0xAABBCCDD with wstrb 0x5 -> read returns 0x11BB33DD.
REQ-035 Contention: both valid held for 4 requests each -> grants D,I,D,I,D,I,D,I and exactly one ready per grant.
REQ-036 Out of range (ram_depth=10): write 0x00001000 then read 0x00000000 -> both ready, read data unchanged, rdata of the OOR access = 0.
REQ-037 Reset asserted in the WAIT cycle of a write to 0x30 (old value 0x0) -> no ready pulse; after release, read 0x30 returns 0x0.
REQ-038 ram_latency=0 and ram_latency=15 sweeps -> ready at exactly t+2 and t+17, respectively.
